sram_axi_arbiter: RTL and testbench

- Shares one AXI4 master port between the instruction and data SRAM-like request interfaces that the pipeline control unit stalls and refreshes on (`req` / `addr_ok` / `data_ok`).
- Sits between the core's fetch/memory stages and the top-level AXI wrapper.
- Sequences independent read and write channel FSMs, at most one outstanding transaction per source.
- Data reads have priority over instruction reads.

---
 rtl/sram_axi_pkg.sv | 34 +++
 rtl/axi_write_ctrl.sv | 92 +++++++++
 rtl/sram_axi_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_sram_axi_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_axi_pkg.sv
// Shared types and constants for the SRAM-to-AXI arbiter.
package sram_axi_pkg;

  typedef enum logic [1:0] {RIdle, RAr, RR} rd_state_e;
  typedef enum logic [1:0] {WIdle, WReq, WB} wr_state_e;

  localparam logic [3:0] ID_INST = 4'd0;
  localparam logic [3:0] ID_DATA = 4'd1;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  // Fixed AXI fields tied off by the wrapper: single beat, INCR, normal access.
  localparam logic [7:0] AXI_LEN        = 8'd0;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic       AXI_LOCK       = 1'b0;
  localparam logic [3:0] AXI_CACHE      = 4'b0000;
  localparam logic [2:0] AXI_PROT       = 3'b000;
  localparam logic       AXI_WLAST      = 1'b1;

  // Byte lanes for a 32-bit write; size 3 yields no enabled lanes.
  function automatic logic [3:0] gen_wstrb(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] strb;
    case (size)
      SIZE_B:  strb = 4'b0001 << addr_lo;
      SIZE_H:  strb = 4'b0011 << {addr_lo[1], 1'b0};
      SIZE_W:  strb = 4'b1111;
      default: strb = 4'b0000;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/axi_write_ctrl.sv
// Write channel FSM: one data write at a time, AW and W handshakes tracked independently.
module axi_write_ctrl
  import sram_axi_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              aclk_i,
  input  logic              aresetn_i,
  input  logic              req_i,
  input  logic              busy_i,
  input  logic [1:0]        size_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              addr_ok_o,
  output logic              data_ok_o,
  output logic [ADDR_W-1:0] awaddr_o,
  output logic [2:0]        awsize_o,
  output logic              awvalid_o,
  input  logic              awready_i,
  output logic [DATA_W-1:0] wdata_o,
  output logic [3:0]        wstrb_o,
  output logic              wvalid_o,
  input  logic              wready_i,
  input  logic              bvalid_i,
  output logic              bready_o
);

  wr_state_e         state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        wstrb_q;
  logic              aw_done_q, w_done_q;
  logic              aw_done, w_done;

  assign addr_ok_o = (state_q == WIdle) && req_i && !busy_i;
  assign awvalid_o = (state_q == WReq) && !aw_done_q;
  assign wvalid_o  = (state_q == WReq) && !w_done_q;
  assign bready_o  = (state_q == WB);
  assign data_ok_o = bready_o && bvalid_i;

  assign aw_done = aw_done_q || (awvalid_o && awready_i);
  assign w_done  = w_done_q || (wvalid_o && wready_i);

  assign awaddr_o = addr_q;
  assign awsize_o = {1'b0, size_q};
  assign wdata_o  = wdata_q;
  assign wstrb_o  = wstrb_q;

  // Write FSM with request latching and per-channel completion flags.
  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      state_q   <= WIdle;
      addr_q    <= '0;
      size_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      case (state_q)
        WIdle: begin
          if (addr_ok_o) begin
            addr_q    <= addr_i;
            size_q    <= size_i;
            wdata_q   <= wdata_i;
            wstrb_q   <= gen_wstrb(size_i, addr_i[1:0]);
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            state_q   <= WReq;
          end
        end
        WReq: begin
          if (aw_done && w_done) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            state_q   <= WB;
          end else begin
            aw_done_q <= aw_done;
            w_done_q  <= w_done;
          end
        end
        WB: begin
          if (bvalid_i) state_q <= WIdle;
        end
        default: state_q <= WIdle;
      endcase
    end
  end

endmodule

// File: rtl/sram_axi_arbiter.sv
// Arbitrates instruction and data SRAM-like requests onto one AXI4 master.
// Build option: SRAM_RDATA_REG_EN registers read data and read data_ok (+1 cycle).
module sram_axi_arbiter
  import sram_axi_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              aclk_i,
  input  logic              aresetn_i,
  input  logic              inst_req_i,
  input  logic              inst_wr_i,
  input  logic [1:0]        inst_size_i,
  input  logic [ADDR_W-1:0] inst_addr_i,
  output logic              inst_addr_ok_o,
  output logic              inst_data_ok_o,
  output logic [DATA_W-1:0] inst_rdata_o,
  input  logic              data_req_i,
  input  logic              data_wr_i,
  input  logic [1:0]        data_size_i,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic [DATA_W-1:0] data_wdata_i,
  output logic              data_addr_ok_o,
  output logic              data_data_ok_o,
  output logic [DATA_W-1:0] data_rdata_o,
  output logic [3:0]        arid_o,
  output logic [ADDR_W-1:0] araddr_o,
  output logic [2:0]        arsize_o,
  output logic              arvalid_o,
  input  logic              arready_i,
  input  logic [3:0]        rid_i,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic              rvalid_i,
  output logic              rready_o,
  output logic [ADDR_W-1:0] awaddr_o,
  output logic [2:0]        awsize_o,
  output logic              awvalid_o,
  input  logic              awready_i,
  output logic [DATA_W-1:0] wdata_o,
  output logic [3:0]        wstrb_o,
  output logic              wvalid_o,
  input  logic              wready_i,
  input  logic              bvalid_i,
  output logic              bready_o
);

  rd_state_e         rd_state_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [1:0]        rd_size_q;
  logic              rd_src_q;  // 1: data source owns the read
  logic              inst_busy_q, data_busy_q;

  logic rd_idle, data_rd_cand, inst_rd_cand, grant_data_rd, grant_inst_rd;
  logic rd_fire, rd_fire_inst, rd_fire_data;
  logic wr_addr_ok, wr_data_ok;

  // Every instruction request is a read.
  logic unused_inst_wr;
  assign unused_inst_wr = inst_wr_i;

  assign rd_idle       = (rd_state_q == RIdle);
  assign data_rd_cand  = data_req_i && !data_wr_i && !data_busy_q;
  assign inst_rd_cand  = inst_req_i && !inst_busy_q;
  assign grant_data_rd = rd_idle && data_rd_cand;
  assign grant_inst_rd = rd_idle && inst_rd_cand && !data_rd_cand;

  assign arid_o    = rd_src_q ? ID_DATA : ID_INST;
  assign araddr_o  = rd_addr_q;
  assign arsize_o  = {1'b0, rd_size_q};
  assign arvalid_o = (rd_state_q == RAr);
  assign rready_o  = (rd_state_q == RR);

  // Response goes to the latched owner regardless of rid.
  assign rd_fire      = rready_o && rvalid_i;
  assign rd_fire_inst = rd_fire && !rd_src_q;
  assign rd_fire_data = rd_fire && rd_src_q;

  assign inst_addr_ok_o = grant_inst_rd;
  assign data_addr_ok_o = grant_data_rd || wr_addr_ok;

  // Read channel FSM.
  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      rd_state_q <= RIdle;
      rd_addr_q  <= '0;
      rd_size_q  <= '0;
      rd_src_q   <= 1'b0;
    end else begin
      case (rd_state_q)
        RIdle: begin
          if (grant_data_rd || grant_inst_rd) begin
            rd_addr_q  <= grant_data_rd ? data_addr_i : inst_addr_i;
            rd_size_q  <= grant_data_rd ? data_size_i : inst_size_i;
            rd_src_q   <= grant_data_rd;
            rd_state_q <= RAr;
          end
        end
        RAr: begin
          if (arready_i) rd_state_q <= RR;
        end
        RR: begin
          if (rvalid_i) rd_state_q <= RIdle;
        end
        default: rd_state_q <= RIdle;
      endcase
    end
  end

`ifdef SRAM_RDATA_REG_EN
  logic              inst_ok_q, data_ok_q;
  logic [DATA_W-1:0] inst_rdata_q, data_rdata_q;

  // Registered read return path.
  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      inst_ok_q    <= 1'b0;
      data_ok_q    <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      inst_ok_q <= rd_fire_inst;
      data_ok_q <= rd_fire_data;
      if (rd_fire_inst) inst_rdata_q <= rdata_i;
      if (rd_fire_data) data_rdata_q <= rdata_i;
    end
  end

  assign inst_data_ok_o = inst_ok_q;
  assign data_data_ok_o = data_ok_q || wr_data_ok;
  assign inst_rdata_o   = inst_rdata_q;
  assign data_rdata_o   = data_rdata_q;
`else
  assign inst_data_ok_o = rd_fire_inst;
  assign data_data_ok_o = rd_fire_data || wr_data_ok;
  assign inst_rdata_o   = rd_fire_inst ? rdata_i : '0;
  assign data_rdata_o   = rd_fire_data ? rdata_i : '0;
`endif

  // One outstanding request per source: set on addr_ok, cleared on data_ok.
  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      inst_busy_q <= 1'b0;
      data_busy_q <= 1'b0;
    end else begin
      if (inst_addr_ok_o)      inst_busy_q <= 1'b1;
      else if (inst_data_ok_o) inst_busy_q <= 1'b0;
      if (data_addr_ok_o)      data_busy_q <= 1'b1;
      else if (data_data_ok_o) data_busy_q <= 1'b0;
    end
  end

  axi_write_ctrl #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_write_ctrl (
    .aclk_i    (aclk_i),
    .aresetn_i (aresetn_i),
    .req_i     (data_req_i && data_wr_i),
    .busy_i    (data_busy_q),
    .size_i    (data_size_i),
    .addr_i    (data_addr_i),
    .wdata_i   (data_wdata_i),
    .addr_ok_o (wr_addr_ok),
    .data_ok_o (wr_data_ok),
    .awaddr_o  (awaddr_o),
    .awsize_o  (awsize_o),
    .awvalid_o (awvalid_o),
    .awready_i (awready_i),
    .wdata_o   (wdata_o),
    .wstrb_o   (wstrb_o),
    .wvalid_o  (wvalid_o),
    .wready_i  (wready_i),
    .bvalid_i  (bvalid_i),
    .bready_o  (bready_o)
  );

  // Slave answered with an ID other than the one issued.
  rid_match_a: assert property (@(posedge aclk_i) disable iff (!aresetn_i)
                                rd_fire |-> (rid_i == arid_o));

endmodule

// File: tb/tb_sram_axi_arbiter.sv
// Directed bench for sram_axi_arbiter with a small zero-wait AXI slave model.
module tb_sram_axi_arbiter;

`ifdef SRAM_RDATA_REG_EN
  localparam int RdLat    = 4;
  localparam int GrantGap = 0;
`else
  localparam int RdLat    = 3;
  localparam int GrantGap = 1;
`endif
  localparam int WrLat = 3;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        inst_req, inst_wr, inst_addr_ok, inst_data_ok;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [3:0]  arid, rid;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [2:0]  arsize, awsize;
  logic        arvalid, arready, rvalid, rready;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;

  // Slave controls and state
  logic        aw_rdy, w_rdy;
  logic [31:0] slave_rdata;
  logic        ar_seen, aw_got, w_got, b_stage;
  logic [3:0]  lat_id;

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  assign arready = 1'b1;
  assign awready = aw_rdy;
  assign wready  = w_rdy;

  sram_axi_arbiter #(
    .ADDR_W (32),
    .DATA_W (32)
  ) dut (
    .aclk_i         (aclk),
    .aresetn_i      (aresetn),
    .inst_req_i     (inst_req),
    .inst_wr_i      (inst_wr),
    .inst_size_i    (inst_size),
    .inst_addr_i    (inst_addr),
    .inst_addr_ok_o (inst_addr_ok),
    .inst_data_ok_o (inst_data_ok),
    .inst_rdata_o   (inst_rdata),
    .data_req_i     (data_req),
    .data_wr_i      (data_wr),
    .data_size_i    (data_size),
    .data_addr_i    (data_addr),
    .data_wdata_i   (data_wdata),
    .data_addr_ok_o (data_addr_ok),
    .data_data_ok_o (data_data_ok),
    .data_rdata_o   (data_rdata),
    .arid_o         (arid),
    .araddr_o       (araddr),
    .arsize_o       (arsize),
    .arvalid_o      (arvalid),
    .arready_i      (arready),
    .rid_i          (rid),
    .rdata_i        (rdata),
    .rvalid_i       (rvalid),
    .rready_o       (rready),
    .awaddr_o       (awaddr),
    .awsize_o       (awsize),
    .awvalid_o      (awvalid),
    .awready_i      (awready),
    .wdata_o        (wdata),
    .wstrb_o        (wstrb),
    .wvalid_o       (wvalid),
    .wready_i       (wready),
    .bvalid_i       (bvalid),
    .bready_o       (bready)
  );

  // Slave: response appears two cycles after the last address/data handshake.
  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ar_seen <= 1'b0; lat_id <= 4'd0; rvalid <= 1'b0; rid <= 4'd0; rdata <= 32'd0;
      aw_got <= 1'b0; w_got <= 1'b0; b_stage <= 1'b0; bvalid <= 1'b0;
    end else begin
      ar_seen <= arvalid && arready;
      if (arvalid && arready) lat_id <= arid;
      if (ar_seen) begin
        rvalid <= 1'b1; rid <= lat_id; rdata <= slave_rdata;
      end else if (rvalid && rready) begin
        rvalid <= 1'b0;
      end
      b_stage <= 1'b0;
      if ((aw_got || (awvalid && awready)) && (w_got || (wvalid && wready))) begin
        aw_got <= 1'b0; w_got <= 1'b0; b_stage <= 1'b1;
      end else begin
        if (awvalid && awready) aw_got <= 1'b1;
        if (wvalid && wready)   w_got  <= 1'b1;
      end
      if (b_stage) bvalid <= 1'b1;
      else if (bvalid && bready) bvalid <= 1'b0;
    end
  end

  typedef struct {
    logic        is_data;
    logic        is_wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdat;
    logic [31:0] srd;
    logic [3:0]  strb;
    logic [2:0]  axsize;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'd2; inst_addr = 32'd0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'd0; data_wdata = 32'd0;
  endtask

  // One complete request from grant to data_ok, with latency and AXI field checks.
  task automatic run_vec(input vec_t v, input int idx);
    logic rd;
    int   lat;
    rd  = !v.is_data || !v.is_wr;
    lat = 0;
    @(negedge aclk);
    slave_rdata = v.srd;
    if (v.is_data) begin
      data_req = 1'b1; data_wr = v.is_wr; data_size = v.size;
      data_addr = v.addr; data_wdata = v.wdat;
    end else begin
      inst_req = 1'b1; inst_wr = v.is_wr; inst_size = v.size; inst_addr = v.addr;
    end
    #1;
    check($sformatf("v%0d addr_ok", idx), 32'(v.is_data ? data_addr_ok : inst_addr_ok), 32'd1);
    @(negedge aclk);
    inst_req = 1'b0; data_req = 1'b0;
    #1;
    if (rd) begin
      check($sformatf("v%0d arvalid", idx), 32'(arvalid), 32'd1);
      check($sformatf("v%0d araddr", idx), araddr, v.addr);
      check($sformatf("v%0d arsize", idx), 32'(arsize), 32'(v.axsize));
      check($sformatf("v%0d arid", idx), 32'(arid), v.is_data ? 32'd1 : 32'd0);
    end else begin
      check($sformatf("v%0d aw/w valid", idx), 32'({awvalid, wvalid}), 32'd3);
      check($sformatf("v%0d awaddr", idx), awaddr, v.addr);
      check($sformatf("v%0d awsize", idx), 32'(awsize), 32'(v.axsize));
      check($sformatf("v%0d wstrb", idx), 32'(wstrb), 32'(v.strb));
      check($sformatf("v%0d wdata", idx), wdata, v.wdat);
    end
    for (int c = 2; c <= 12 && lat == 0; c++) begin
      @(negedge aclk);
      #1;
      if (v.is_data ? data_data_ok : inst_data_ok) begin
        lat = c;
        if (rd) check($sformatf("v%0d rdata", idx), v.is_data ? data_rdata : inst_rdata, v.srd);
      end
    end
    check($sformatf("v%0d latency", idx), 32'(lat), rd ? 32'(RdLat) : 32'(WrLat));
  endtask

  initial begin
    int dok_c, ig_c, cnt, early, icount, seen, granted;

    // is_data, is_wr, size, addr, wdata, slave rdata, wstrb, axsize
    vecs[0] = '{1'b0, 1'b0, 2'd2, 32'hBFC0_0000, 32'h0, 32'h3C1D_0001, 4'b0000, 3'd2};
    vecs[1] = '{1'b1, 1'b0, 2'd1, 32'h8000_0102, 32'h0, 32'h1234_ABCD, 4'b0000, 3'd1};
    vecs[2] = '{1'b1, 1'b1, 2'd0, 32'h8000_0003, 32'h0000_00AB, 32'h0, 4'b1000, 3'd0};
    vecs[3] = '{1'b1, 1'b1, 2'd0, 32'h8000_0001, 32'h0000_CD00, 32'h0, 4'b0010, 3'd0};
    vecs[4] = '{1'b1, 1'b1, 2'd1, 32'h8000_0002, 32'hBEEF_0000, 32'h0, 4'b1100, 3'd1};
    vecs[5] = '{1'b1, 1'b1, 2'd1, 32'h8000_0000, 32'h0000_BEEF, 32'h0, 4'b0011, 3'd1};
    vecs[6] = '{1'b1, 1'b1, 2'd2, 32'h8000_0010, 32'hDEAD_BEEF, 32'h0, 4'b1111, 3'd2};
    vecs[7] = '{1'b1, 1'b1, 2'd3, 32'h8000_0004, 32'h5555_AAAA, 32'h0, 4'b0000, 3'd3};
    vecs[8] = '{1'b0, 1'b1, 2'd0, 32'h0000_0007, 32'h0, 32'hA5A5_5A5A, 4'b0000, 3'd0};

    aresetn = 1'b0; aw_rdy = 1'b1; w_rdy = 1'b1; slave_rdata = 32'd0;
    idle_inputs();
    #1;
    check("rst valids", 32'({arvalid, awvalid, wvalid}), 32'd0);
    check("rst readys", 32'({rready, bready}), 32'd0);
    check("rst addr_ok", 32'({inst_addr_ok, data_addr_ok}), 32'd0);
    check("rst data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
    check("rst inst_rdata", inst_rdata, 32'd0);
    check("rst data_rdata", data_rdata, 32'd0);
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Simultaneous inst and data reads: data first, inst follows its data_ok.
    @(negedge aclk);
    inst_req = 1'b1; inst_size = 2'd2; inst_addr = 32'h0000_1000;
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h8000_2000;
    slave_rdata = 32'h1111_2222;
    #1;
    check("A data_addr_ok", 32'(data_addr_ok), 32'd1);
    check("A inst_addr_ok", 32'(inst_addr_ok), 32'd0);
    @(negedge aclk);
    data_req = 1'b0;
    #1;
    check("A arid data", 32'(arid), 32'd1);
    check("A araddr data", araddr, 32'h8000_2000);
    dok_c = -1; ig_c = -1;
    for (int c = 2; c <= 15 && ig_c < 0; c++) begin
      @(negedge aclk);
      #1;
      if (data_data_ok) begin
        dok_c = c;
        check("A data rdata", data_rdata, 32'h1111_2222);
        slave_rdata = 32'h3333_4444;
      end
      if (inst_addr_ok) ig_c = c;
    end
    check("A data_ok cycle", 32'(dok_c), 32'(RdLat));
    check("A inst grant gap", 32'(ig_c - dok_c), 32'(GrantGap));
    @(negedge aclk);
    inst_req = 1'b0;
    #1;
    check("A arid inst", 32'(arid), 32'd0);
    check("A araddr inst", araddr, 32'h0000_1000);
    seen = 0;
    for (int c = 0; c < 10 && seen == 0; c++) begin
      @(negedge aclk);
      #1;
      if (inst_data_ok) begin
        seen = 1;
        check("A inst rdata", inst_rdata, 32'h3333_4444);
      end
    end
    check("A inst data_ok seen", 32'(seen), 32'd1);

    // Write with awready held off; wready immediate.
    @(negedge aclk);
    aw_rdy = 1'b0;
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2;
    data_addr = 32'h8000_3000; data_wdata = 32'h0BAD_F00D;
    #1;
    check("B addr_ok", 32'(data_addr_ok), 32'd1);
    @(negedge aclk);
    data_req = 1'b0;
    #1;
    check("B c1 valids", 32'({awvalid, wvalid}), 32'd3);
    @(negedge aclk);
    #1;
    check("B c2 valids", 32'({awvalid, wvalid, bready}), 32'b100);
    @(negedge aclk);
    #1;
    check("B c3 awvalid", 32'(awvalid), 32'd1);
    @(negedge aclk);
    aw_rdy = 1'b1;
    #1;
    check("B c4 awvalid", 32'({awvalid, bready}), 32'b10);
    cnt = 0;
    for (int c = 5; c < 15; c++) begin
      @(negedge aclk);
      #1;
      if (c == 5) check("B c5 bready", 32'({awvalid, wvalid, bready}), 32'b001);
      if (data_data_ok) cnt++;
    end
    check("B data_ok count", 32'(cnt), 32'd1);

    // Write in flight with a concurrent inst read; second data request held off.
    @(negedge aclk);
    slave_rdata = 32'h7777_8888;
    inst_req = 1'b1; inst_size = 2'd2; inst_addr = 32'h0000_4000;
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2;
    data_addr = 32'h8000_5000; data_wdata = 32'h0000_0001;
    #1;
    check("C both addr_ok", 32'({data_addr_ok, inst_addr_ok}), 32'b11);
    @(negedge aclk);
    inst_req = 1'b0;
    data_addr = 32'h8000_6000; data_wdata = 32'h0000_0002;
    #1;
    check("C second held", 32'(data_addr_ok), 32'd0);
    early = 0; icount = 0; seen = 0;
    for (int c = 2; c <= 15 && seen == 0; c++) begin
      @(negedge aclk);
      #1;
      if (data_addr_ok) early = 1;
      if (inst_data_ok) begin
        icount++;
        check("C inst rdata", inst_rdata, 32'h7777_8888);
      end
      if (data_data_ok) seen = 1;
    end
    check("C first write done", 32'(seen), 32'd1);
    check("C held until data_ok", 32'(early), 32'd0);
    granted = 0;
    for (int c = 0; c < 10 && granted == 0; c++) begin
      @(negedge aclk);
      #1;
      if (inst_data_ok) icount++;
      if (data_addr_ok) granted = 1;
    end
    check("C second granted", 32'(granted), 32'd1);
    @(negedge aclk);
    data_req = 1'b0;
    #1;
    check("C second awaddr", awaddr, 32'h8000_6000);
    seen = 0;
    for (int c = 0; c < 10 && seen == 0; c++) begin
      @(negedge aclk);
      #1;
      if (inst_data_ok) icount++;
      if (data_data_ok) seen = 1;
    end
    check("C second write done", 32'(seen), 32'd1);
    check("C inst data_ok count", 32'(icount), 32'd1);
    idle_inputs();

    // Reset during the read response phase.
    @(negedge aclk);
    inst_req = 1'b1; inst_addr = 32'h0000_5000; slave_rdata = 32'hFFFF_0000;
    @(negedge aclk);
    inst_req = 1'b0;
    @(negedge aclk);
    #1;
    check("D in R phase", 32'(rready), 32'd1);
    aresetn = 1'b0;
    #1;
    check("D rst arvalid/rready", 32'({arvalid, rready}), 32'd0);
    check("D rst data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
    check("D rst inst_rdata", inst_rdata, 32'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    run_vec(vecs[0], 100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
